// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Packet framing states of the loader.
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RUN
  } loader_state_t;

  // Packet sync byte.
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory programming bus of the loader.
// The master side is the loader; the slave side is the surrounding
// system (UART receiver, instruction memory and core).
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        busy;
  logic        error;

  modport master (
    input  rx_valid, rx_data,
    output prog_en, prog_addr, prog_data, start, busy, error
  );

  modport slave (
    output rx_valid, rx_data,
    input  prog_en, prog_addr, prog_data, start, busy, error
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four consecutive payload bytes into a little-endian 32-bit word.
// The first byte of a word ends up in bits [7:0]. word/word_done are
// combinational views of the byte currently being presented, so the
// parent can register the finished word in the same cycle as the 4th byte.
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  // Only the first three bytes need storage; the fourth comes straight in.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;

  // Next-state for the byte shifter and the lane counter.
  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (clear) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (byte_valid) begin
      shift_d = {byte_in, shift_q[23:8]};
      lane_d  = lane_q + 2'd1;
    end
  end

  // Register the shifter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      lane_q  <= '0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

  assign word      = {byte_in, shift_q};
  assign word_done = byte_valid && !clear && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: frames a UART byte stream into a load packet, writes
// the payload words into instruction memory and releases the core only
// once the packet checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC          = LOADER_MAGIC,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.master     bus
);

  loader_state_t state_q, state_d;
  logic [31:0]   n_q, n_d;
  logic [1:0]    len_cnt_q, len_cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [31:0]   word_idx_q, word_idx_d;
  logic [31:0]   idle_q, idle_d;
  logic          prog_en_q, prog_en_d;
  logic [31:0]   prog_addr_q, prog_addr_d;
  logic [31:0]   prog_data_q, prog_data_d;
  logic          start_q, start_d;
  logic          error_q, error_d;

  logic [31:0]   n_shift;
  logic [31:0]   asm_word;
  logic          asm_done;
  logic          asm_clear;
  logic          asm_valid;

  // The assembler only runs while payload bytes are expected; anywhere
  // else it is held cleared so every packet starts on lane 0.
  assign asm_clear = (state_q != DATA);
  assign asm_valid = (state_q == DATA) && bus.rx_valid;
  assign n_shift   = {bus.rx_data, n_q[31:8]};

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .word_done  (asm_done)
  );

  // Packet FSM, checksum, word index, idle timeout and output next-state.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    len_cnt_d   = len_cnt_q;
    sum_d       = sum_q;
    word_idx_d  = word_idx_q;
    idle_d      = idle_q;
    prog_en_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    start_d     = start_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
          state_d    = LEN;
          error_d    = 1'b0;
          n_d        = '0;
          len_cnt_d  = '0;
          sum_d      = '0;
          word_idx_d = '0;
          idle_d     = '0;
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          n_d       = n_shift;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            if (n_shift > 32'(MAX_WORDS)) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else if (n_shift == 32'd0) begin
              state_d = CSUM;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          sum_d = sum_q + bus.rx_data;
          if (asm_done) begin
            prog_en_d   = 1'b1;
            prog_addr_d = BASE_ADDR + (word_idx_q << 2);
            prog_data_d = asm_word;
            word_idx_d  = word_idx_q + 32'd1;
            if (word_idx_q == (n_q - 32'd1)) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            state_d = RUN;
            start_d = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        start_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte timeout inside a packet; a byte in the same cycle wins.
    if ((state_q == LEN) || (state_q == DATA) || (state_q == CSUM)) begin
      if (bus.rx_valid) begin
        idle_d = '0;
      end else if (idle_q >= (TIMEOUT_CYCLES - 1)) begin
        idle_d  = '0;
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
  end

  // State and output registers; reset also suppresses any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      len_cnt_q   <= '0;
      sum_q       <= '0;
      word_idx_q  <= '0;
      idle_q      <= '0;
      prog_en_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      start_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      len_cnt_q   <= len_cnt_d;
      sum_q       <= sum_d;
      word_idx_q  <= word_idx_d;
      idle_q      <= idle_d;
      prog_en_q   <= prog_en_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      start_q     <= start_d;
      error_q     <= error_d;
    end
  end

  assign bus.prog_en   = prog_en_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.start     = start_q;
  assign bus.error     = error_q;
  assign bus.busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

endmodule
